// File: rtl/stream_demultiplexer_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demultiplexer_if
//  Description : Handshake bundle for stream_demultiplexer. It carries one
//                upstream valid/ready channel with a destination select, and
//                SIZE downstream valid/ready channels with their payloads.
//                A sticky error flag reports beats that named a channel
//                which does not exist.
//  Ports       : none (signal bundle only)
//                in_select  - destination channel index of the offered beat
//                in_data    - offered payload
//                in_valid   - upstream offers in_select/in_data
//                in_ready   - block accepts this cycle
//                out_data   - per-channel payload (all copies of the head)
//                out_valid  - per-channel offer, at most one bit set
//                out_ready  - per-channel downstream accept
//                error      - sticky out-of-range select flag
//  Modports    : master - the side that feeds and drains the block
//                slave  - the demultiplexer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_demultiplexer_if #(
    parameter int  SIZE = 2,
    parameter type T    = logic
);
    logic [$clog2(SIZE)-1:0] in_select;
    T                        in_data;
    logic                    in_valid;
    logic                    in_ready;
    T [SIZE-1:0]             out_data;
    logic [SIZE-1:0]         out_valid;
    logic [SIZE-1:0]         out_ready;
    logic                    error;

    modport master (
        output in_select,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  error
    );

    modport slave (
        input  in_select,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output error
    );
endinterface
`default_nettype wire

// File: rtl/stream_demultiplexer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demultiplexer
//  Description : Routes a single input stream to one of SIZE output channels.
//                Each accepted {select, data} beat is held in a two-entry
//                FIFO and offered, in acceptance order, on the channel it
//                selects. The head entry blocks every later entry until its
//                own channel takes it, so order across channels is kept.
//                A beat naming a channel >= SIZE is consumed and dropped,
//                and sets a sticky error flag.
//  Parameters  : SIZE - number of output channels (>= 2)
//                T    - payload type of every channel
//  Ports       : clk   - clock, all state changes on its rising edge
//                reset - synchronous, active-high
//                bus   - stream_demultiplexer_if.slave handshake bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_demultiplexer #(
    parameter int  SIZE = 2,
    parameter type T    = logic
) (
    input  wire logic               clk,
    input  wire logic               reset,
    stream_demultiplexer_if.slave   bus
);

    localparam int SEL_W = $clog2(SIZE);

    // One extra bit so SIZE itself is representable for the range check.
    localparam logic [SEL_W:0] c_size  = SIZE[SEL_W:0];
    localparam logic [1:0]     c_depth = 2'd2;

    // ------------------------------------------------------------------
    // FIFO state. Storage is not reset: an entry is only ever read while
    // the count says it is occupied, and out_data carries no meaning while
    // out_valid is low.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] r_sel  [2];
    T                 r_data [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;
    logic             r_error;

    logic             w_ready;
    logic             w_accept;
    logic             w_in_range;
    logic             w_enq;
    logic             w_pop;
    logic [SEL_W-1:0] w_head_sel;

    // Ready depends only on the registered count, so downstream readiness
    // never ripples back to the upstream port within a cycle. A pop at full
    // therefore frees its slot for the following cycle only.
    assign w_ready    = (r_count != c_depth);
    assign w_accept   = bus.in_valid && w_ready;
    assign w_in_range = ({1'b0, bus.in_select} < c_size);
    assign w_enq      = w_accept && w_in_range;

    assign w_head_sel = r_sel[r_head];

    // Only the channel being offered can complete a transfer; ready bits of
    // the other channels are don't-care.
    assign w_pop      = (r_count != 2'd0) && bus.out_ready[w_head_sel];

    // ------------------------------------------------------------------
    // Pointers, occupancy and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            r_error <= 1'b0;
        end else begin
            // Two entries: advancing a pointer is a simple toggle.
            if (w_enq) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end

            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            // An out-of-range beat is still handshaken away; only the flag
            // remembers it.
            if (w_accept && !w_in_range) begin
                r_error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_sel[r_tail]  <= bus.in_select;
            r_data[r_tail] <= bus.in_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. No bypass path: a beat is visible only once it is stored.
    // ------------------------------------------------------------------
    always_comb begin
        bus.out_valid = '0;
        if (r_count != 2'd0) begin
            bus.out_valid[w_head_sel] = 1'b1;
        end
    end

    // The payload is qualified by out_valid alone, so every channel simply
    // sees the head entry's data.
    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < SIZE; k++) begin
            bus.out_data[k] = r_data[r_head];
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.error    = r_error;

endmodule
`default_nettype wire
